// File: rtl/sgd_pkg.sv
// Shared definitions for the SGD model write-back path: data geometry,
// burst limits, error flag bit positions and the command slot record.
package sgd_pkg;

    localparam int SGD_DATA_W          = 512;
    localparam int BYTES_PER_BEAT      = 64;
    localparam int BEAT_OFS_W          = 6;
    localparam int SGD_MAX_BURST_BYTES = 4096;

    // err_flags bit positions
    localparam int ERR_DATA_OVF = 0;
    localparam int ERR_CMD_OVF  = 1;
    localparam int ERR_ZERO_LEN = 2;
    localparam int ERR_MISALIGN = 3;

    // One write-back command held in the active or pending slot.
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] remaining;
        logic        valid;
    } sgd_wr_cmd_t;

endpackage

// File: rtl/sgd_wr_data_fifo.sv
// First-word-fall-through data FIFO between the write-back stream and the
// memory write data channel. The head word is visible on rd_data whenever
// empty is low. almost_full is registered from the occupancy count.
module sgd_wr_data_fifo #(
    parameter int DATA_W       = 512,
    parameter int FIFO_DEPTH   = 64,
    parameter int AFULL_THRESH = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered threshold flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            almost_full <= (count >= (AW+1)'(AFULL_THRESH));
        end
    end

endmodule

// File: rtl/sgd_x_mem_write_ctrl.sv
// Memory-write controller behind the SGD model write-back stage.
// Captures write-back commands into an active/pending slot pair, buffers
// the model stream in a FWFT FIFO and splits each command into bursts that
// never cross a MAX_BURST_BYTES boundary.
// Optional feature: define SGD_WR_STATS_EN to build the words_written /
// bursts_issued counters; otherwise both outputs are tied to 0.
module sgd_x_mem_write_ctrl
    import sgd_pkg::*;
#(
    parameter int DATA_W          = SGD_DATA_W,
    parameter int FIFO_DEPTH      = 64,
    parameter int AFULL_THRESH    = 48,
    parameter int MAX_BURST_BYTES = SGD_MAX_BURST_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x_data_send_back_start,
    input  logic [63:0]       x_data_send_back_addr,
    input  logic [31:0]       x_data_send_back_length,
    input  logic [DATA_W-1:0] x_data_out,
    input  logic              x_data_out_valid,
    output logic              x_data_out_almost_full,
    output logic              mem_wr_cmd_valid,
    input  logic              mem_wr_cmd_ready,
    output logic [63:0]       mem_wr_cmd_addr,
    output logic [31:0]       mem_wr_cmd_len,
    output logic              mem_wr_data_valid,
    input  logic              mem_wr_data_ready,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_data_last,
    output logic              busy,
    output logic [3:0]        err_flags,
    output logic [31:0]       words_written,
    output logic [31:0]       bursts_issued
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t            state;
    sgd_wr_cmd_t       active;
    sgd_wr_cmd_t       pending;
    sgd_wr_cmd_t       active_nx;
    sgd_wr_cmd_t       pending_nx;
    logic              start_q;
    logic [63:0]       last_addr;
    logic [31:0]       beats_left;

    logic [63:0]       addr_al;
    logic [31:0]       len_al;
    logic              new_det;
    logic              zero_len;
    logic              misaligned;
    logic              cmd_ok;
    logic              cmd_drop;

    logic              cmd_fire;
    logic              beat_fire;
    logic              last_fire;
    logic [63:0]       next_addr;
    logic [31:0]       next_rem;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_afull;
    logic [DATA_W-1:0] fifo_rd_data;

    // Largest burst from addr that fits both the remaining bytes and the
    // room left before the next MAX_BURST_BYTES boundary.
    function automatic logic [31:0] burst_len(input logic [63:0] addr,
                                              input logic [31:0] remaining);
        logic [31:0] room;
        room = 32'(MAX_BURST_BYTES) - 32'(addr & 64'(MAX_BURST_BYTES - 1));
        return (remaining < room) ? remaining : room;
    endfunction

    // Command decode: the upstream holds start high and only moves addr,
    // so a new command is a rising start or a changed address.
    assign addr_al    = x_data_send_back_addr & ~64'(BYTES_PER_BEAT - 1);
    assign len_al     = x_data_send_back_length & ~32'(BYTES_PER_BEAT - 1);
    assign new_det    = x_data_send_back_start &&
                        (!start_q || (x_data_send_back_addr != last_addr));
    assign zero_len   = (x_data_send_back_length == '0);
    assign misaligned = (|x_data_send_back_addr[BEAT_OFS_W-1:0]) ||
                        (|x_data_send_back_length[BEAT_OFS_W-1:0]);
    assign cmd_ok     = new_det && (len_al != '0);

    // Handshakes and the position after the current burst completes.
    assign cmd_fire   = mem_wr_cmd_valid && mem_wr_cmd_ready;
    assign beat_fire  = mem_wr_data_valid && mem_wr_data_ready;
    assign last_fire  = beat_fire && (beats_left == 32'd1);
    assign next_addr  = active.addr + {32'd0, mem_wr_cmd_len};
    assign next_rem   = active.remaining - mem_wr_cmd_len;

    // The data channel is qualified by state; data is forced to 0 when idle.
    assign mem_wr_data_valid      = (state == S_DATA) && !fifo_empty;
    assign mem_wr_data            = mem_wr_data_valid ? fifo_rd_data : '0;
    assign mem_wr_data_last       = mem_wr_data_valid && (beats_left == 32'd1);
    assign busy                   = active.valid || pending.valid;
    assign x_data_out_almost_full = fifo_afull;

    sgd_wr_data_fifo #(
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (x_data_out_valid),
        .wr_data     (x_data_out),
        .rd_en       (beat_fire),
        .rd_data     (fifo_rd_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .almost_full (fifo_afull)
    );

    // Next slot contents: retire/advance the active command first, then
    // place a newly detected command into whichever slot is free afterwards.
    always_comb begin
        active_nx  = active;
        pending_nx = pending;
        cmd_drop   = 1'b0;
        if (last_fire) begin
            if (next_rem != '0) begin
                active_nx.addr      = next_addr;
                active_nx.remaining = next_rem;
            end else if (pending.valid) begin
                active_nx  = pending;
                pending_nx = '0;
            end else begin
                active_nx = '0;
            end
        end
        if (cmd_ok) begin
            if (!active_nx.valid) begin
                active_nx = '{addr: addr_al, remaining: len_al, valid: 1'b1};
            end else if (!pending_nx.valid) begin
                pending_nx = '{addr: addr_al, remaining: len_al, valid: 1'b1};
            end else begin
                cmd_drop = 1'b1;
            end
        end
    end

    // Burst FSM with registered command outputs, slot state and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            active           <= '0;
            pending          <= '0;
            start_q          <= 1'b0;
            last_addr        <= '0;
            beats_left       <= '0;
            mem_wr_cmd_valid <= 1'b0;
            mem_wr_cmd_addr  <= '0;
            mem_wr_cmd_len   <= '0;
            err_flags        <= '0;
        end else begin
            start_q <= x_data_send_back_start;
            if (new_det) begin
                last_addr <= x_data_send_back_addr;
            end
            active  <= active_nx;
            pending <= pending_nx;

            if (x_data_out_valid && fifo_full) begin
                err_flags[ERR_DATA_OVF] <= 1'b1;
            end
            if (cmd_drop) begin
                err_flags[ERR_CMD_OVF] <= 1'b1;
            end
            if (new_det && zero_len) begin
                err_flags[ERR_ZERO_LEN] <= 1'b1;
            end
            if (new_det && misaligned) begin
                err_flags[ERR_MISALIGN] <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (active.valid) begin
                        state            <= S_CMD;
                        mem_wr_cmd_valid <= 1'b1;
                        mem_wr_cmd_addr  <= active.addr;
                        mem_wr_cmd_len   <= burst_len(active.addr, active.remaining);
                    end
                end
                S_CMD: begin
                    if (cmd_fire) begin
                        mem_wr_cmd_valid <= 1'b0;
                        beats_left       <= mem_wr_cmd_len >> BEAT_OFS_W;
                        state            <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat_fire) begin
                        beats_left <= beats_left - 32'd1;
                        if (last_fire) begin
                            if ((next_rem != '0) || pending.valid) begin
                                state            <= S_CMD;
                                mem_wr_cmd_valid <= 1'b1;
                                mem_wr_cmd_addr  <= active_nx.addr;
                                mem_wr_cmd_len   <= burst_len(active_nx.addr,
                                                              active_nx.remaining);
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SGD_WR_STATS_EN
    // Wrapping counters of beats and bursts accepted by memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_written <= '0;
            bursts_issued <= '0;
        end else begin
            if (beat_fire) begin
                words_written <= words_written + 32'd1;
            end
            if (cmd_fire) begin
                bursts_issued <= bursts_issued + 32'd1;
            end
        end
    end
`else
    assign words_written = '0;
    assign bursts_issued = '0;
`endif

endmodule

// File: doc/sgd_x_mem_write_ctrl.md
# sgd_x_mem_write_ctrl

Memory-write controller directly downstream of the SGD model write-back stage. Captures write-back commands (start/addr/length) and the 512-bit model stream. Buffers data in a local FIFO and back-pressures upstream via `x_data_out_almost_full`. Splits each command into bursts that never cross a MAX_BURST_BYTES boundary and drives them onto the memory write command/data channels with valid/ready handshakes.

## Interface
- DATA_W, 512, data beat width (64 B per beat).
- FIFO_DEPTH, 64, data FIFO entries; must be a power of 2.
- AFULL_THRESH, 48, FIFO count at which almost_full asserts; FIFO_DEPTH-AFULL_THRESH ≥ 8.
- MAX_BURST_BYTES, 4096, burst size limit and alignment boundary; must be a power of 2.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- x_data_send_back_start  in  1  command request level.
- x_data_send_back_addr  in  64  command byte address.
- x_data_send_back_length  in  32  command byte length.
- x_data_out  in  DATA_W  write-back data.
- x_data_out_valid  in  1  data qualifier; no ready, always accepted.
- x_data_out_almost_full  out  1  registered back-pressure to upstream.
- mem_wr_cmd_valid / mem_wr_cmd_ready  out / in  1  burst command handshake.
- mem_wr_cmd_addr  out  64  burst byte address.
- mem_wr_cmd_len  out  32  burst byte length.
- mem_wr_data_valid / mem_wr_data_ready  out / in  1  data handshake.
- mem_wr_data  out  DATA_W  data beat.
- mem_wr_data_last  out  1  last beat of burst.
- busy  out  1  command active or pending.
- err_flags  out  4  sticky errors: [0] data overflow, [1] cmd overflow, [2] zero length, [3] misaligned.
- words_written  out  32  beats accepted by memory (stats).
- bursts_issued  out  32  commands accepted by memory (stats).

## Operation
- **New-command detect.** A command is detected when start=1 and (start was 0 last cycle, or addr ≠ last captured addr). The upstream holds start high across epochs and only changes addr.
- **Zero length.** Length 0 sets err[2]; the command is dropped.
- **Misalignment.** Non-zero addr[5:0] or length[5:0] sets err[3]. Those bits are then treated as 0, after which a length that becomes 0 is also dropped.
- **Command slots.** Two slots: active and pending.
  - A command detected while active is free and pending is empty goes to active.
  - Otherwise it goes to pending.
  - If both are full, the command is dropped and err[1] is set.
- **FSM.**
  - IDLE: active valid → CMD.
  - CMD: burst_len = min(remaining, MAX_BURST_BYTES − (addr mod MAX_BURST_BYTES)). Assert cmd_valid with addr/len. On cmd_ready → DATA, and set beats = burst_len/64.
  - DATA: emit a beat when FIFO is non-empty. Pop on valid&ready. last=1 on the final beat of the burst. After the last beat: addr += burst_len, remaining −= burst_len.
    - remaining > 0 → CMD.
    - remaining = 0 and pending valid → promote pending, → CMD.
    - otherwise → IDLE.
- **Data FIFO.**
  - Every x_data_out_valid cycle pushes a word; a push when full is dropped and sets err[0].
  - almost_full = (count ≥ AFULL_THRESH), registered.
  - FIFO contents are not tied to commands. Data may arrive before its command is captured.
- **Errors.** err_flags are cleared only by reset.
- **Reset.** All outputs 0; FSM IDLE; FIFO empty; slots empty.
- **Reset mid-burst.** Abandons the burst immediately with no last beat. Memory-side recovery is the system's responsibility.

## Timing
- Start detected at cycle t → cmd_valid high at t+2 when IDLE.
- cmd_valid and addr/len are held stable until ready.
- **FIFO.** First-word-fall-through. Data pushed at t is visible on mem_wr_data at t+1, at the earliest when in DATA.
- **Burst turnaround.**
  - Last beat accepted at t → next cmd_valid at t+1 (state CMD).
  - Back-to-back bursts cost one command cycle.
- **Almost-full.**
  - Asserts the cycle after count reaches AFULL_THRESH and deasserts the cycle after count drops below it.
  - Upstream tolerates ≤8 further beats after assertion.
- **Simultaneity.**
  - Push and pop in the same cycle leave count unchanged.
  - A new command detected in the same cycle the active command completes is written directly to the active slot if pending is empty.
- Sustained throughput: one beat per cycle when data_ready=1.

## Configuration
- SGD_WR_STATS_EN defined: words_written and bursts_issued are 32-bit wrapping counters, incremented on data and cmd handshakes, reset to 0.
- SGD_WR_STATS_EN undefined: counters are not built and both outputs are tied to 0.

## Structure
- Shared package sgd_pkg holds:
  - DATA_W, BYTES_PER_BEAT (64), the MAX_BURST_BYTES default.
  - The err_flags bit index constants.
  - The typedef `sgd_wr_cmd_t` (addr 64, remaining 32, valid), used for both slots.
- One sub-module, `sgd_wr_data_fifo`: a synchronous FWFT FIFO (DATA_W × FIFO_DEPTH) with count, full, empty and threshold almost_full.
- The FSM and burst-split arithmetic stay in the top module.

## Test plan
- **Single burst.** addr 0x1000, length 256, 4 words pushed → one cmd (0x1000, 256); 4 beats; last on beat 4; busy falls after.
- **Boundary split.** addr 0x0FC0, length 256 → cmds (0x0FC0, 64) then (0x1000, 192); last on beats 1 and 4.
- **Large command.** addr 0, length 8192 → two cmds of 4096 at 0x0 and 0x1000, 64 beats each; bursts_issued=2, words_written=128 when SGD_WR_STATS_EN is defined.
- **Back-pressure.** data_ready=0, 56 words pushed over consecutive cycles → almost_full high the cycle after count=48; FIFO reaches 56 < 64, so err[0] stays 0. Release ready → all 56 beats delivered in order.
- **Command overflow.** start held high while addr steps through 0x0, 0x4000, 0x8000 during one active command → the second command is pending, the third is dropped with err[1]=1. The first two still complete in order.
- **Errors and reset.** length 0 → err[2]=1, no cmd. Then rst_n=0 mid-DATA → all outputs 0 next cycle, FIFO empty, err_flags 0.
